// File: rtl/ac_match_controller.sv
// Aho-Corasick match sequencer: walks the goto table per character, follows failure links on a miss.
// Define AC_CTRL_INIT_FILE_EN to reset the goto count to GOTO_DEPTH; tables are written through the config port.
module ac_match_controller #(
  parameter int STATE_W    = 8,
  parameter int CHAR_W     = 4,
  parameter int GOTO_DEPTH = 32,
  parameter int FAIL_DEPTH = 32
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               CFG_WE,
  input  logic [1:0]         CFG_SEL,
  input  logic [4:0]         CFG_ADDR,
  input  logic [19:0]        CFG_DATA,
  input  logic               CHAR_VALID,
  input  logic [CHAR_W-1:0]  CHAR_IN,
  output logic               CHAR_READY,
  output logic               OUT_VALID,
  output logic [STATE_W-1:0] NOW_STATE,
  output logic               MATCH,
  output logic               BUSY,
  output logic               ERR
);
  localparam int AW = $clog2(GOTO_DEPTH);
  localparam int FW = $clog2(FAIL_DEPTH);
  localparam int CW = $clog2(GOTO_DEPTH + 1);
  localparam int HW = $clog2(FAIL_DEPTH + 1);

  typedef enum logic [1:0] {S_IDLE, S_SCAN, S_HOP, S_DONE} st_t;

  logic [STATE_W-1:0] goto_cur [GOTO_DEPTH];
  logic [CHAR_W-1:0]  goto_chr [GOTO_DEPTH];
  logic [STATE_W-1:0] goto_nxt [GOTO_DEPTH];
  logic [STATE_W-1:0] fail_mem [FAIL_DEPTH];
  logic               out_mem  [FAIL_DEPTH];

`ifdef AC_CTRL_INIT_FILE_EN
  localparam logic [CW-1:0] CNT_RST = CW'(GOTO_DEPTH);
`else
  localparam logic [CW-1:0] CNT_RST = '0;
`endif

  st_t                state;
  logic [CW-1:0]      goto_cnt;
  logic [AW-1:0]      scan_idx;
  logic [HW-1:0]      hops;
  logic [CHAR_W-1:0]  char_q;

  logic               accept, cfg_ok, hit, last;
  logic [STATE_W-1:0] ent_cur, ent_nxt, fail_rd;
  logic [CHAR_W-1:0]  ent_chr;
  logic [CW-1:0]      cnt_sat;

  // States outside the failure/output tables read as 0.
  function automatic logic out_of(input logic [STATE_W-1:0] s);
    return (32'(s) < FAIL_DEPTH) ? out_mem[s[FW-1:0]] : 1'b0;
  endfunction

  assign accept  = (state == S_IDLE) && CHAR_VALID && CHAR_READY;
  assign cfg_ok  = CFG_WE && (state == S_IDLE) && !accept;
  assign ent_cur = goto_cur[scan_idx];
  assign ent_chr = goto_chr[scan_idx];
  assign ent_nxt = goto_nxt[scan_idx];
  assign hit     = (goto_cnt != '0) && (ent_cur == NOW_STATE) && (ent_chr == char_q);
  assign last    = (goto_cnt == '0) || (CW'(scan_idx) == goto_cnt - CW'(1));
  assign fail_rd = (32'(NOW_STATE) < FAIL_DEPTH) ? fail_mem[NOW_STATE[FW-1:0]] : '0;
  assign cnt_sat = (32'(CFG_DATA[5:0]) > GOTO_DEPTH) ? CW'(GOTO_DEPTH) : CW'(CFG_DATA[5:0]);
  assign BUSY    = (state != S_IDLE);

  always_ff @(posedge CLK) begin
    if (cfg_ok) begin
      case (CFG_SEL)
        2'd0: begin
          goto_cur[CFG_ADDR[AW-1:0]] <= CFG_DATA[19:12];
          goto_chr[CFG_ADDR[AW-1:0]] <= CFG_DATA[11:8];
          goto_nxt[CFG_ADDR[AW-1:0]] <= CFG_DATA[7:0];
        end
        2'd1:    fail_mem[CFG_ADDR[FW-1:0]] <= CFG_DATA[STATE_W-1:0];
        2'd2:    out_mem[CFG_ADDR[FW-1:0]]  <= CFG_DATA[0];
        default: ;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state      <= S_IDLE;
      NOW_STATE  <= '0;
      OUT_VALID  <= 1'b0;
      MATCH      <= 1'b0;
      ERR        <= 1'b0;
      CHAR_READY <= 1'b1;
      goto_cnt   <= CNT_RST;
      scan_idx   <= '0;
      hops       <= '0;
    end else begin
      if (cfg_ok && CFG_SEL == 2'd3) goto_cnt <= cnt_sat;
      case (state)
        S_IDLE: if (accept) begin
          char_q     <= CHAR_IN;
          scan_idx   <= '0;
          hops       <= '0;
          CHAR_READY <= 1'b0;
          state      <= S_SCAN;
        end
        S_SCAN: begin
          if (hit) begin
            NOW_STATE <= ent_nxt;
            MATCH     <= out_of(ent_nxt);
            OUT_VALID <= 1'b1;
            state     <= S_DONE;
          end else if (last) begin
            scan_idx <= '0;
            // Root has an implicit self-loop on every unmatched character.
            if (NOW_STATE == '0) begin
              MATCH     <= out_of('0);
              OUT_VALID <= 1'b1;
              state     <= S_DONE;
            end else begin
              state <= S_HOP;
            end
          end else begin
            scan_idx <= scan_idx + AW'(1);
          end
        end
        S_HOP: begin
          if (hops == HW'(FAIL_DEPTH)) begin
            NOW_STATE <= '0;
            ERR       <= 1'b1;
            MATCH     <= out_of('0);
            OUT_VALID <= 1'b1;
            state     <= S_DONE;
          end else begin
            NOW_STATE <= fail_rd;
            hops      <= hops + HW'(1);
            scan_idx  <= '0;
            state     <= S_SCAN;
          end
        end
        S_DONE: begin
          OUT_VALID  <= 1'b0;
          MATCH      <= 1'b0;
          CHAR_READY <= 1'b1;
          state      <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_ac_match_controller.sv
// Directed bench for ac_match_controller: hand-computed states, match flags and accept-to-result latencies.
module tb_ac_match_controller;
  logic        CLK = 1'b0, RST = 1'b1, CFG_WE = 1'b0;
  logic [1:0]  CFG_SEL = '0;
  logic [4:0]  CFG_ADDR = '0;
  logic [19:0] CFG_DATA = '0;
  logic        CHAR_VALID = 1'b0;
  logic [3:0]  CHAR_IN = '0;
  logic        CHAR_READY, OUT_VALID, MATCH, BUSY, ERR;
  logic [7:0]  NOW_STATE;

  int total = 0, bad = 0;

  ac_match_controller dut (
    .CLK(CLK), .RST(RST), .CFG_WE(CFG_WE), .CFG_SEL(CFG_SEL), .CFG_ADDR(CFG_ADDR),
    .CFG_DATA(CFG_DATA), .CHAR_VALID(CHAR_VALID), .CHAR_IN(CHAR_IN), .CHAR_READY(CHAR_READY),
    .OUT_VALID(OUT_VALID), .NOW_STATE(NOW_STATE), .MATCH(MATCH), .BUSY(BUSY), .ERR(ERR)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic cfg_wr(input logic [1:0] sel, input logic [4:0] addr, input logic [19:0] data);
    @(negedge CLK);
    CFG_WE = 1'b1; CFG_SEL = sel; CFG_ADDR = addr; CFG_DATA = data;
    @(negedge CLK);
    CFG_WE = 1'b0;
  endtask

  task automatic do_rst();
    @(negedge CLK); RST = 1'b1;
    @(negedge CLK); RST = 1'b0;
  endtask

  // Latency counts cycles from the accept cycle (0) to the cycle OUT_VALID is high.
  task automatic run(input string tag, input logic [3:0] c, input int elat,
                     input logic [7:0] est, input logic em, input bit chk_m);
    int lat;
    @(negedge CLK);
    chk({tag, "_rdy"}, CHAR_READY, 1'b1);
    CHAR_VALID = 1'b1; CHAR_IN = c;
    @(negedge CLK);
    CHAR_VALID = 1'b0;
    lat = 1;
    while (!OUT_VALID && lat < 300) begin
      @(negedge CLK);
      lat++;
    end
    chk({tag, "_lat"}, lat, elat);
    chk({tag, "_st"}, NOW_STATE, est);
    if (chk_m) chk({tag, "_m"}, MATCH, em);
    @(negedge CLK);
    chk({tag, "_pulse"}, OUT_VALID, 1'b0);
  endtask

  initial begin
    bit ov_seen;
    repeat (2) @(negedge CLK);
    chk("rst_st", NOW_STATE, 8'h00);
    chk("rst_ov", OUT_VALID, 1'b0);
    chk("rst_m", MATCH, 1'b0);
    chk("rst_err", ERR, 1'b0);
    chk("rst_rdy", CHAR_READY, 1'b1);
    chk("rst_busy", BUSY, 1'b0);
    RST = 1'b0;

    // Empty goto table: immediate miss at root.
    run("cnt0", 4'h3, 2, 8'h00, 1'b0, 1'b0);

    cfg_wr(2'd0, 5'd0, 20'h00B01);
    cfg_wr(2'd0, 5'd1, 20'h01C02);
    cfg_wr(2'd3, 5'd0, 20'h00002);
    cfg_wr(2'd2, 5'd0, 20'h0);
    cfg_wr(2'd2, 5'd1, 20'h0);
    cfg_wr(2'd2, 5'd2, 20'h1);
    cfg_wr(2'd2, 5'd3, 20'h1);
    cfg_wr(2'd2, 5'd4, 20'h1);
    cfg_wr(2'd1, 5'd1, 20'h0);
    cfg_wr(2'd1, 5'd2, 20'h0);
    cfg_wr(2'd1, 5'd3, 20'h0);
    cfg_wr(2'd1, 5'd4, 20'h0);

    run("hitB", 4'hB, 2, 8'h01, 1'b0, 1'b1);
    run("hitC", 4'hC, 3, 8'h02, 1'b1, 1'b1);
    // From 2: two-entry miss, hop to 0, two-entry miss at root.
    run("hop_root", 4'h5, 6, 8'h00, 1'b0, 1'b1);
    run("root_miss", 4'h5, 3, 8'h00, 1'b0, 1'b1);

    cfg_wr(2'd0, 5'd1, 20'h00C03);
    run("toB", 4'hB, 2, 8'h01, 1'b0, 1'b1);
    run("hopC", 4'hC, 6, 8'h03, 1'b1, 1'b1);

    cfg_wr(2'd1, 5'd1, 20'h1);
    run("hopB", 4'hB, 5, 8'h01, 1'b0, 1'b1);
    // Self-loop at 1: 33 hop cycles plus 66 scan cycles, then DONE.
    run("loop", 4'h7, 100, 8'h00, 1'b0, 1'b1);
    chk("loop_err", ERR, 1'b1);

    run("toB2", 4'hB, 2, 8'h01, 1'b0, 1'b1);
    // Accept with a simultaneous cfg write, then a cfg write mid-scan: both dropped.
    @(negedge CLK);
    CHAR_VALID = 1'b1; CHAR_IN = 4'h7;
    CFG_WE = 1'b1; CFG_SEL = 2'd2; CFG_ADDR = 5'd1; CFG_DATA = 20'h1;
    @(negedge CLK);
    CHAR_VALID = 1'b0;
    CFG_SEL = 2'd0; CFG_ADDR = 5'd0; CFG_DATA = 20'h00B05;
    @(negedge CLK);
    CFG_WE = 1'b0;
    chk("scan_busy", BUSY, 1'b1);
    chk("scan_rdy", CHAR_READY, 1'b0);
    chk("scan_err", ERR, 1'b1);
    RST = 1'b1;
    @(negedge CLK);
    RST = 1'b0;
    chk("abort_st", NOW_STATE, 8'h00);
    chk("abort_busy", BUSY, 1'b0);
    chk("abort_rdy", CHAR_READY, 1'b1);
    chk("abort_err", ERR, 1'b0);
    ov_seen = OUT_VALID;
    for (int i = 0; i < 5; i++) begin
      @(negedge CLK);
      ov_seen |= OUT_VALID;
    end
    chk("abort_ov", ov_seen, 1'b0);
    cfg_wr(2'd3, 5'd0, 20'h00002);
    run("tbl_kept", 4'hB, 2, 8'h01, 1'b0, 1'b1);

    // Full table, count written above GOTO_DEPTH must saturate to 32.
    for (int i = 2; i < 31; i++) cfg_wr(2'd0, 5'(i), 20'hFFF00);
    cfg_wr(2'd0, 5'd31, 20'h00D04);
    do_rst();
    cfg_wr(2'd3, 5'd0, 20'h0003F);
    run("sat_hit", 4'hD, 33, 8'h04, 1'b1, 1'b1);
    run("sat_miss", 4'hE, 66, 8'h00, 1'b0, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
